// File: rtl/fx_arb.sv
// Two-requester round-robin arbiter onto the fx register bus.
// Serialises one transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK.
module fx_arb #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m0_wdata,
  input  logic [7:0]  m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [7:0]  m0_rdata,
  output logic [7:0]  m1_rdata,
  output logic        fx_wr,
  output logic        fx_rd,
  output logic [15:0] fx_waddr,
  output logic [15:0] fx_raddr,
  output logic [7:0]  fx_data,
  input  logic [7:0]  fx_q,
  output logic        busy,
  output logic        gnt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t      state;
  state_t      state_nxt;
  logic        last_gnt;
  logic        cur_wr;
  logic [2:0]  wait_cnt;
  logic        grant;
  logic        capture;
  logic        win_id;
  logic        win_wr;
  logic [15:0] win_addr;
  logic [7:0]  win_wdata;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    win_id    = (m0_req && m1_req) ? ~last_gnt : m1_req;
    win_wr    = win_id ? m1_wr    : m0_wr;
    win_addr  = win_id ? m1_addr  : m0_addr;
    win_wdata = win_id ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    busy      = (state != IDLE);
    m0_ack    = (state == ACK) && !gnt_id;
    m1_ack    = (state == ACK) &&  gnt_id;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = cur_wr ? ACK : WAIT;
      WAIT: begin
        if (wait_cnt == 3'd1) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered on the grant edge so they are high exactly for
  // the ISSUE cycle; address/data registers keep their value afterwards.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      fx_waddr <= 16'h0000;
      fx_raddr <= 16'h0000;
      fx_data  <= 8'h00;
      m0_rdata <= 8'h00;
      m1_rdata <= 8'h00;
      gnt_id   <= 1'b0;
      last_gnt <= 1'b1;
      cur_wr   <= 1'b0;
      wait_cnt <= 3'd0;
    end else begin
      fx_wr <= 1'b0;
      fx_rd <= 1'b0;
      if (grant) begin
        gnt_id <= win_id;
        cur_wr <= win_wr;
        if (win_wr) begin
          fx_wr    <= 1'b1;
          fx_waddr <= win_addr;
          fx_data  <= win_wdata;
        end else begin
          fx_rd    <= 1'b1;
          fx_raddr <= win_addr;
        end
      end
      if (state == ISSUE) begin
        wait_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (capture) begin
        if (gnt_id) begin
          m1_rdata <= fx_q;
        end else begin
          m0_rdata <= fx_q;
        end
      end
      if (state == ACK) begin
        last_gnt <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_fx_arb.sv
// Bench for fx_arb: two instances (RD_LAT 1 and 3) behind a simple fx slave,
// directed vector table, hand-written corner sequences and a random phase.
module tb_fx_arb;

  localparam int LAT0  = 1;
  localparam int LAT1  = 3;
  localparam int NADDR = 8;
  localparam int NVEC  = 8;
  localparam int NRAND = 40;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst      [2];
  logic        m0_req   [2];
  logic        m1_req   [2];
  logic        m0_wr    [2];
  logic        m1_wr    [2];
  logic [15:0] m0_addr  [2];
  logic [15:0] m1_addr  [2];
  logic [7:0]  m0_wdata [2];
  logic [7:0]  m1_wdata [2];
  logic        m0_ack   [2];
  logic        m1_ack   [2];
  logic [7:0]  m0_rdata [2];
  logic [7:0]  m1_rdata [2];
  logic        fx_wr    [2];
  logic        fx_rd    [2];
  logic [15:0] fx_waddr [2];
  logic [15:0] fx_raddr [2];
  logic [7:0]  fx_data  [2];
  logic [7:0]  fx_q     [2];
  logic        busy     [2];
  logic        gnt_id   [2];

  fx_arb #(.RD_LAT(LAT0)) u_dut0 (
    .clk_sys(clk_sys), .rst(rst[0]),
    .m0_req(m0_req[0]), .m1_req(m1_req[0]), .m0_wr(m0_wr[0]), .m1_wr(m1_wr[0]),
    .m0_addr(m0_addr[0]), .m1_addr(m1_addr[0]), .m0_wdata(m0_wdata[0]), .m1_wdata(m1_wdata[0]),
    .m0_ack(m0_ack[0]), .m1_ack(m1_ack[0]), .m0_rdata(m0_rdata[0]), .m1_rdata(m1_rdata[0]),
    .fx_wr(fx_wr[0]), .fx_rd(fx_rd[0]), .fx_waddr(fx_waddr[0]), .fx_raddr(fx_raddr[0]),
    .fx_data(fx_data[0]), .fx_q(fx_q[0]), .busy(busy[0]), .gnt_id(gnt_id[0])
  );

  fx_arb #(.RD_LAT(LAT1)) u_dut1 (
    .clk_sys(clk_sys), .rst(rst[1]),
    .m0_req(m0_req[1]), .m1_req(m1_req[1]), .m0_wr(m0_wr[1]), .m1_wr(m1_wr[1]),
    .m0_addr(m0_addr[1]), .m1_addr(m1_addr[1]), .m0_wdata(m0_wdata[1]), .m1_wdata(m1_wdata[1]),
    .m0_ack(m0_ack[1]), .m1_ack(m1_ack[1]), .m0_rdata(m0_rdata[1]), .m1_rdata(m1_rdata[1]),
    .fx_wr(fx_wr[1]), .fx_rd(fx_rd[1]), .fx_waddr(fx_waddr[1]), .fx_raddr(fx_raddr[1]),
    .fx_data(fx_data[1]), .fx_q(fx_q[1]), .busy(busy[1]), .gnt_id(gnt_id[1])
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          wr_pulses [2] = '{0, 0};
  int          rd_pulses [2] = '{0, 0};
  int          scnt      [2] = '{0, 0};
  logic [7:0]  sdat      [2] = '{8'h00, 8'h00};
  logic [7:0]  smem      [2][NADDR] = '{'{default: 8'h00}, '{default: 8'h00}};
  logic [7:0]  mdl       [2][NADDR] = '{'{default: 8'h00}, '{default: 8'h00}};
  bit          mdl_known [2][NADDR] = '{'{default: 1'b0}, '{default: 1'b0}};
  int          pend_since[2][2]     = '{'{-1, -1}, '{-1, -1}};
  int          last_ack  [2]        = '{-1, -1};

  typedef struct {
    bit          who;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  rdata;
  } vec_t;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] tab_addr(input int k);
    case (k)
      0:       return 16'h0380;
      1:       return 16'h0201;
      2:       return 16'h0100;
      3:       return 16'h1207;
      4:       return 16'h2AFF;
      5:       return 16'h0000;
      6:       return 16'h3E10;
      default: return 16'h3F00;
    endcase
  endfunction

  // Slave decodes the first NADDR-1 table addresses; the last one is unmapped.
  function automatic int addr_idx(input logic [15:0] a);
    for (int k = 0; k < NADDR - 1; k++) begin
      if (tab_addr(k) == a) return k;
    end
    return -1;
  endfunction

  function automatic logic ack_of(input int i, input bit who);
    return who ? m1_ack[i] : m0_ack[i];
  endfunction

  function automatic logic [7:0] rdata_of(input int i, input bit who);
    return who ? m1_rdata[i] : m0_rdata[i];
  endfunction

  task automatic drive_req(input int i, input bit who, input bit req, input bit wr,
                           input logic [15:0] a, input logic [7:0] wd);
    if (who) begin
      m1_req[i] = req; m1_wr[i] = wr; m1_addr[i] = a; m1_wdata[i] = wd;
    end else begin
      m0_req[i] = req; m0_wr[i] = wr; m0_addr[i] = a; m0_wdata[i] = wd;
    end
  endtask

  task automatic set_req(input int i, input bit who, input bit v);
    if (who) m1_req[i] = v;
    else     m0_req[i] = v;
  endtask

  task automatic chk_reset_outputs(input int i, input string tag);
    chk({tag, "_m0_ack"},   32'(m0_ack[i]),   0);
    chk({tag, "_m1_ack"},   32'(m1_ack[i]),   0);
    chk({tag, "_m0_rdata"}, 32'(m0_rdata[i]), 0);
    chk({tag, "_m1_rdata"}, 32'(m1_rdata[i]), 0);
    chk({tag, "_fx_wr"},    32'(fx_wr[i]),    0);
    chk({tag, "_fx_rd"},    32'(fx_rd[i]),    0);
    chk({tag, "_fx_waddr"}, 32'(fx_waddr[i]), 0);
    chk({tag, "_fx_raddr"}, 32'(fx_raddr[i]), 0);
    chk({tag, "_fx_data"},  32'(fx_data[i]),  0);
    chk({tag, "_busy"},     32'(busy[i]),     0);
    chk({tag, "_gnt_id"},   32'(gnt_id[i]),   0);
  endtask

  task automatic run_txn(input int i, input bit who, input bit wr, input logic [15:0] a,
                         input logic [7:0] wd, output int lat, output logic [7:0] rd);
    lat = -1;
    drive_req(i, who, 1'b1, wr, a, wd);
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ack_of(i, who)) begin
        lat = n;
        break;
      end
    end
    set_req(i, who, 1'b0);
    rd = rdata_of(i, who);
  endtask

  // Requester that raises a random transaction, holds req until its ack and
  // scores the result against a memory model kept in completion order.
  task automatic rand_master(input int i, input bit who, input int ntx);
    int          idx, g, other;
    bit          wr, got;
    logic [7:0]  wd;
    logic [15:0] a;
    for (int t = 0; t < ntx; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      a  = tab_addr(int'($urandom_range(0, NADDR - 1)));
      idx = addr_idx(a);
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      pend_since[i][who] = cyc;
      drive_req(i, who, 1'b1, wr, a, wd);
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        tick();
        got = ack_of(i, who);
      end
      set_req(i, who, 1'b0);
      pend_since[i][who] = -1;
      chk("rand_ack_timeout", 32'(got), 1);
      if (got) begin
        g = cyc - (wr ? 2 : 2 + ((i == 0) ? LAT0 : LAT1));
        other = pend_since[i][!who];
        chk("rand_round_robin", 32'(last_ack[i] == int'(who) && other >= 0 && other <= g), 0);
        last_ack[i] = int'(who);
        if (wr) begin
          if (idx >= 0) begin
            mdl[i][idx] = wd;
            mdl_known[i][idx] = 1'b1;
          end
        end else if (idx < 0) begin
          chk("rand_unmapped_rdata", 32'(rdata_of(i, who)), 0);
        end else if (mdl_known[i][idx]) begin
          chk("rand_rdata", 32'(rdata_of(i, who)), 32'(mdl[i][idx]));
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  // fx slave (read data appears only in the RD_LAT-th cycle after fx_rd) and
  // bus-level invariant monitor.
  initial forever begin
    @(negedge clk_sys);
    for (int g = 0; g < 2; g++) begin
      chk("strobe_exclusive", 32'(fx_wr[g] & fx_rd[g]), 0);
      chk("ack_exclusive",    32'(m0_ack[g] & m1_ack[g]), 0);
      if (scnt[g] != 0) begin
        scnt[g] = scnt[g] - 1;
        fx_q[g] = (scnt[g] == 0) ? sdat[g] : 8'h00;
      end else begin
        fx_q[g] = 8'h00;
      end
      if (fx_rd[g]) begin
        scnt[g] = (g == 0) ? LAT0 : LAT1;
        sdat[g] = (addr_idx(fx_raddr[g]) >= 0) ? smem[g][addr_idx(fx_raddr[g])] : 8'h00;
        rd_pulses[g]++;
      end
      if (fx_wr[g]) begin
        if (addr_idx(fx_waddr[g]) >= 0) smem[g][addr_idx(fx_waddr[g])] = fx_data[g];
        wr_pulses[g]++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int         lat, w0, r0, nack, c0;
    int         order [4];
    int         ack_c [4];
    bit         seen;
    logic [7:0] rd;

    vecs[0] = '{1'b0, 1'b1, 16'h0380, 8'h5A, 2, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 16'h0380, 8'h00, 3, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 16'h1207, 8'hC3, 2, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 16'h1207, 8'h00, 3, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 16'h3F00, 8'h00, 3, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 16'h0201, 8'h00, 3, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 16'h0201, 8'hE1, 2, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 16'h0201, 8'h00, 3, 8'hE1};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      drive_req(i, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      drive_req(i, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    end
    tick();
    tick();
    chk_reset_outputs(0, "por0");
    chk_reset_outputs(1, "por1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    for (int v = 0; v < NVEC; v++) begin
      w0 = wr_pulses[0];
      r0 = rd_pulses[0];
      run_txn(0, vecs[v].who, vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rd);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("vec%0d_wr_strobes", v), 32'(wr_pulses[0] - w0), vecs[v].wr ? 1 : 0);
      chk($sformatf("vec%0d_rd_strobes", v), 32'(rd_pulses[0] - r0), vecs[v].wr ? 0 : 1);
      if (vecs[v].wr) begin
        chk($sformatf("vec%0d_fx_waddr", v), 32'(fx_waddr[0]), 32'(vecs[v].addr));
        chk($sformatf("vec%0d_fx_data", v),  32'(fx_data[0]),  32'(vecs[v].wdata));
      end else begin
        chk($sformatf("vec%0d_fx_raddr", v), 32'(fx_raddr[0]), 32'(vecs[v].addr));
        chk($sformatf("vec%0d_rdata", v),    32'(rd),          32'(vecs[v].rdata));
      end
      tick();
    end

    // Reset after traffic, then both requesters held: m0, m1, m0, m1.
    rst[0] = 1'b1;
    tick();
    tick();
    chk_reset_outputs(0, "rst0");
    rst[0] = 1'b0;
    tick();
    foreach (order[k]) begin
      order[k] = -1;
      ack_c[k] = -1;
    end
    c0 = cyc;
    nack = 0;
    drive_req(0, 1'b0, 1'b1, 1'b1, 16'h0100, 8'h11);
    drive_req(0, 1'b1, 1'b1, 1'b1, 16'h2AFF, 8'h22);
    for (int n = 0; n < 40 && nack < 4; n++) begin
      tick();
      if (m0_ack[0] || m1_ack[0]) begin
        order[nack] = m1_ack[0] ? 1 : 0;
        ack_c[nack] = cyc - c0;
        nack++;
      end
    end
    set_req(0, 1'b0, 1'b0);
    set_req(0, 1'b1, 1'b0);
    chk("rr_ack_count", 32'(nack), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));
      chk($sformatf("rr_ack_cycle%0d", k), 32'(ack_c[k]), 32'(2 + 3 * k));
    end
    tick();

    // Write whose requester drops req while in ISSUE still completes once.
    w0 = wr_pulses[0];
    drive_req(0, 1'b0, 1'b1, 1'b1, 16'h0380, 8'hA5);
    tick();
    chk("drop_issue_fx_wr",    32'(fx_wr[0]),    1);
    chk("drop_issue_fx_waddr", 32'(fx_waddr[0]), 32'h0380);
    chk("drop_issue_fx_data",  32'(fx_data[0]),  32'hA5);
    set_req(0, 1'b0, 1'b0);
    tick();
    chk("drop_issue_ack", 32'(m0_ack[0]), 1);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (m0_ack[0] || m1_ack[0] || busy[0]) seen = 1'b1;
    end
    chk("drop_issue_no_extra", 32'(seen), 0);
    chk("drop_issue_wr_count", 32'(wr_pulses[0] - w0), 1);

    // RD_LAT=3 instance: data shows only on the third cycle after fx_rd.
    run_txn(1, 1'b1, 1'b1, 16'h0100, 8'h07, lat, rd);
    chk("lat3_write_latency", 32'(lat), 2);
    tick();
    run_txn(1, 1'b0, 1'b0, 16'h0100, 8'h00, lat, rd);
    chk("lat3_read_latency", 32'(lat), 5);
    chk("lat3_read_rdata",   32'(rd),  32'h07);
    tick();

    // Reset during WAIT aborts the read; a later read is unaffected.
    r0 = rd_pulses[1];
    drive_req(1, 1'b0, 1'b1, 1'b0, 16'h0100, 8'h00);
    tick();
    chk("abort_fx_rd", 32'(fx_rd[1]), 1);
    set_req(1, 1'b0, 1'b0);
    tick();
    chk("abort_busy_in_wait", 32'(busy[1]), 1);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("abort_busy",     32'(busy[1]),     0);
    chk("abort_m0_ack",   32'(m0_ack[1]),   0);
    chk("abort_m0_rdata", 32'(m0_rdata[1]), 0);
    chk("abort_fx_raddr", 32'(fx_raddr[1]), 0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (m0_ack[1] || m1_ack[1] || busy[1]) seen = 1'b1;
    end
    chk("abort_no_ack", 32'(seen), 0);
    chk("abort_rd_count", 32'(rd_pulses[1] - r0), 1);
    run_txn(1, 1'b1, 1'b0, 16'h0100, 8'h00, lat, rd);
    chk("after_abort_latency", 32'(lat), 5);
    chk("after_abort_rdata",   32'(rd),  32'h07);
    tick();

    fork
      rand_master(0, 1'b0, NRAND);
      rand_master(0, 1'b1, NRAND);
      rand_master(1, 1'b0, NRAND);
      rand_master(1, 1'b1, NRAND);
    join
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fx_arb.md
FX_ARB -- requirements
Module: fx_arb

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning cycles from fx_rd assertion to valid fx_q (legal range 1..7).
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports m0_req / m1_req  input  1 each  requester transaction request, held high until that requester's ack.
REQ-005 SHALL have ports m0_wr / m1_wr  input  1 each  1=write, 0=read; stable while req high.
REQ-006 SHALL have ports m0_addr / m1_addr  input  16 each  fx bus address (bits 13:8 select module, bits 7:0 register).
REQ-007 SHALL have ports m0_wdata / m1_wdata  input  8 each  write data.
REQ-008 SHALL have ports m0_ack / m1_ack  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata / m1_rdata  output  8 each  read data, valid in ack cycle, held until next ack to same requester.
REQ-010 SHALL have ports fx_wr, fx_rd  output  1 each  fx bus strobes.
REQ-011 SHALL have ports fx_waddr, fx_raddr  output  16 each; fx_data  output  8; fx_q  input  8 (OR of all slave read registers).
REQ-012 SHALL have ports busy  output  1 (state not IDLE) and gnt_id  output  1 (requester owning current/last transaction).

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, ACK.
REQ-014 IDLE: if any req high, SHALL latch winner's wr/addr/wdata and id, go to ISSUE next cycle; else stay IDLE.
REQ-015 Arbitration SHALL be round-robin: both requesting -> grant the requester not granted last; single request -> grant it.
REQ-016 ISSUE (exactly one cycle): write -> fx_wr=1, fx_waddr=addr, fx_data=wdata, next ACK; read -> fx_rd=1, fx_raddr=addr, next WAIT.
REQ-017 WAIT SHALL last exactly RD_LAT cycles via 3-bit down-counter; fx_q SHALL be captured into granted rdata register on last WAIT cycle; next ACK.
REQ-018 ACK (one cycle): granted mN_ack=1, other ack=0; last-grant pointer updated to gnt_id; next IDLE.
REQ-019 Latency: req seen in IDLE cycle T -> write ack at T+2; read fx_rd at T+1, capture at T+1+RD_LAT, ack at T+2+RD_LAT.
REQ-020 fx_wr and fx_rd SHALL never be high together and SHALL be high only in ISSUE.
REQ-021 fx_waddr/fx_raddr/fx_data SHALL hold last driven values outside ISSUE.
REQ-022 Request deasserted mid-transaction SHALL NOT abort it; transaction completes with ack.
REQ-023 Req held high after ack SHALL be treated as new transaction, subject to round-robin (other requester wins if pending).
REQ-024 Requests arriving outside IDLE SHALL wait; no request lost while held high.
REQ-025 Read of unmapped address returns fx_q as sampled (0x00 from bus); no error flag.

Reset
REQ-026 rst high on clock edge SHALL force IDLE, all outputs 0 (acks, strobes, addresses, fx_data, rdata, busy, gnt_id), last-grant=1 so m0 wins first tie.
REQ-027 rst asserted mid-transaction SHALL abort it with no ack and no further strobe.

Verification
REQ-028 Reset, then m0 write addr 0x0380 data 0x5A -> fx_wr=1 one cycle with fx_waddr=0x0380, fx_data=0x5A; m0_ack 2 cycles after req seen.
REQ-029 m1 read 0x0380, fx_q driven 0x5A in cycle after fx_rd (RD_LAT=1) -> m1_rdata=0x5A with m1_ack 3 cycles after req seen.
REQ-030 m0 and m1 request same cycle after reset, both held -> order m0, m1, m0, m1; ack never simultaneous.
REQ-031 RD_LAT=3, read 0x0100 with fx_q=0x07 only 3 cycles after fx_rd -> rdata=0x07, ack 5 cycles after req.
REQ-032 rst asserted in WAIT -> no ack, busy=0 next cycle, subsequent m1 read completes normally.
REQ-033 m0 drops req in cycle after ISSUE of write -> ack still issued; no second fx_wr.
